// File: rtl/board_pkg.sv
// Shared definitions for the battleship board renderer: cell codes, VGA 640x480@60
// timing limits, palette and board geometry.
package board_pkg;

  typedef enum logic [1:0] {
    AGUA        = 2'b00,
    BARCO       = 2'b01,
    ATACA_BARCO = 2'b10,
    ATACA_AGUA  = 2'b11
  } cell_t;

  // Sync limits are inclusive pixel/line indices.
  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;
  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  localparam int CELL_SIZE = 64;
  localparam int CELLS     = 5;
  localparam int BOARD_PIX = CELL_SIZE * CELLS;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_DGREY  = 24'h202020;
  localparam logic [23:0] COL_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
  localparam logic [23:0] COL_BLUE   = 24'h0000C0;
  localparam logic [23:0] COL_GREEN  = 24'h00C000;
  localparam logic [23:0] COL_RED    = 24'hC00000;
  localparam logic [23:0] COL_LGREY  = 24'hA0A0A0;

  function automatic logic [23:0] cell_colour(input logic [1:0] code);
    logic [23:0] colour;
    case (code)
      AGUA:        colour = COL_BLUE;
      BARCO:       colour = COL_GREEN;
      ATACA_BARCO: colour = COL_RED;
      default:     colour = COL_LGREY;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and 800x525 raster counters producing raw sync, visible
// flag and the start-of-frame strobe.
import board_pkg::*;

module vga_timing #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  // pix_en is registered so it stays low in reset even when CLK_DIV is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else if (div == DW'(CLK_DIV - 1)) begin
      div    <= '0;
      pix_en <= 1'b1;
    end else begin
      div    <= div + 1'b1;
      pix_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == 10'(H_TOTAL - 1)) begin
        hc <= '0;
        vc <= (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign visible     = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
  assign hsync_raw   = !((hc >= 10'(H_SYNC_START)) && (hc <= 10'(H_SYNC_END)));
  assign vsync_raw   = !((vc >= 10'(V_SYNC_START)) && (vc <= 10'(V_SYNC_END)));
  assign frame_start = pix_en && (hc == 10'd0) && (vc == 10'd0);

endmodule

// File: rtl/board_renderer.sv
// Draws the player and PC 5x5 boards side by side on a 640x480 VGA raster.
// Define BOARD_CURSOR_EN to overlay the yellow cursor cell.
import board_pkg::*;

module board_renderer #(
  parameter int CLK_DIV  = 2,
  parameter int BOARD_Y0 = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tablero_jugador [0:4][0:4],
  input  logic [1:0] tablero_pc      [0:4][0:4],
  input  logic [2:0] i_actual,
  input  logic [2:0] j_actual,
  input  logic       cursor_on_pc,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_start
);

  logic       pix_en, visible, hsync_raw, vsync_raw;
  logic [9:0] hc, vc;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hc         (hc),
    .vc         (vc),
    .visible    (visible),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_start(frame_start)
  );

  // Bit 10 of yo_full is the borrow, i.e. the row lies above the boards.
  logic [10:0] yo_full;
  logic [3:0]  col_c;
  logic        board_sel_c, inboard_c, grid_c;

  assign yo_full     = {1'b0, vc} - 11'(BOARD_Y0);
  assign board_sel_c = (hc >= 10'(BOARD_PIX));
  assign col_c       = board_sel_c ? (hc[9:6] - 4'(CELLS)) : hc[9:6];
  assign inboard_c   = visible && !yo_full[10] && (yo_full[9:0] <= 10'(BOARD_PIX - 1));
  assign grid_c      = (hc[5:0] == 6'd0) || (yo_full[5:0] == 6'd0) ||
                       (hc == 10'(H_VISIBLE - 1)) || (yo_full[9:0] == 10'(BOARD_PIX - 1));

  logic       s1_visible, s1_inboard, s1_sel, s1_grid, s1_hsync, s1_vsync;
  logic [2:0] s1_row, s1_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_visible <= 1'b0;
      s1_inboard <= 1'b0;
      s1_sel     <= 1'b0;
      s1_grid    <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
    end else if (pix_en) begin
      s1_visible <= visible;
      s1_inboard <= inboard_c;
      s1_sel     <= board_sel_c;
      s1_grid    <= grid_c;
      s1_row     <= yo_full[8:6];
      s1_col     <= col_c[2:0];
      s1_hsync   <= hsync_raw;
      s1_vsync   <= vsync_raw;
    end
  end

  // Boards are read live; off-board coordinates fall back to a harmless code.
  logic [1:0] cell_c;
  always_comb begin
    cell_c = AGUA;
    if ((s1_row < 3'(CELLS)) && (s1_col < 3'(CELLS)))
      cell_c = s1_sel ? tablero_pc[s1_row][s1_col] : tablero_jugador[s1_row][s1_col];
  end

  logic cursor_hit, unused_bits;
`ifdef BOARD_CURSOR_EN
  assign cursor_hit  = s1_inboard && !s1_grid && (s1_sel == cursor_on_pc) &&
                       (s1_row == i_actual) && (s1_col == j_actual);
  assign unused_bits = col_c[3];
`else
  assign cursor_hit  = 1'b0;
  assign unused_bits = ^{col_c[3], i_actual, j_actual, cursor_on_pc};
`endif

  logic [23:0] colour_c;
  always_comb begin
    colour_c = COL_BLACK;
    if (!s1_visible)      colour_c = COL_BLACK;
    else if (!s1_inboard) colour_c = COL_DGREY;
    else if (s1_grid)     colour_c = COL_WHITE;
    else if (cursor_hit)  colour_c = COL_YELLOW;
    else                  colour_c = cell_colour(cell_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      g       <= '0;
      b       <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else if (pix_en) begin
      r       <= colour_c[23:16];
      g       <= colour_c[15:8];
      b       <= colour_c[7:0];
      hsync   <= s1_hsync;
      vsync   <= s1_vsync;
      blank_n <= s1_visible;
    end
  end

  assign vga_clk = pix_en;
  assign sync_n  = 1'b0;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: two instances (fast divider with boards at
// the top, default geometry) checked every clock against a pixel-rule reference model.
module tb_board_renderer;

  localparam int D1 = 1;
  localparam int Y1 = 0;
  localparam int D2 = 2;
  localparam int Y2 = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tab_j  [0:4][0:4];
  logic [1:0] tab_pc [0:4][0:4];
  logic [2:0] i_act, j_act;
  logic       cur_pc;

  logic       vclk1, hs1, vs1, bn1, sn1, fs1;
  logic [7:0] r1, g1, b1;
  logic       vclk2, hs2, vs2, bn2, sn2, fs2;
  logic [7:0] r2, g2, b2;

  board_renderer #(.CLK_DIV(D1), .BOARD_Y0(Y1)) dut1 (
    .clk(clk), .rst(rst), .tablero_jugador(tab_j), .tablero_pc(tab_pc),
    .i_actual(i_act), .j_actual(j_act), .cursor_on_pc(cur_pc),
    .vga_clk(vclk1), .hsync(hs1), .vsync(vs1), .blank_n(bn1), .sync_n(sn1),
    .r(r1), .g(g1), .b(b1), .frame_start(fs1)
  );

  board_renderer #(.CLK_DIV(D2), .BOARD_Y0(Y2)) dut2 (
    .clk(clk), .rst(rst), .tablero_jugador(tab_j), .tablero_pc(tab_pc),
    .i_actual(i_act), .j_actual(j_act), .cursor_on_pc(cur_pc),
    .vga_clk(vclk2), .hsync(hs2), .vsync(vs2), .blank_n(bn2), .sync_n(sn2),
    .r(r2), .g(g2), .b(b2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    int          hc;
    int          vc;
    logic [23:0] rgb;
  } vec_t;

  vec_t vtab [16];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Colour of pixel (hc,vc) from the drawing rules, using the current board inputs.
  function automatic logic [23:0] refPixel(input int hc, input int vc, input int y0);
    int yo, row, col;
    logic pc;
    logic [1:0] code;
    if (hc >= 640 || vc >= 480) return 24'h000000;
    yo = vc - y0;
    if (yo < 0 || yo > 319) return 24'h202020;
    if (hc % 64 == 0 || yo % 64 == 0 || hc == 639 || yo == 319) return 24'hFFFFFF;
    pc  = (hc >= 320);
    col = hc / 64 - (pc ? 5 : 0);
    row = yo / 64;
`ifdef BOARD_CURSOR_EN
    if (pc == cur_pc && row == int'(i_act) && col == int'(j_act)) return 24'hFFFF00;
`endif
    code = pc ? tab_pc[row][col] : tab_j[row][col];
    case (code)
      2'd0:    return 24'h0000C0;
      2'd1:    return 24'h00C000;
      2'd2:    return 24'hC00000;
      default: return 24'hA0A0A0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Fixed board pattern on the lines that carry table entries, random boards elsewhere.
  task automatic applyStimulus(input int line);
    if (line <= 3 || line == 65 || line == 66) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          tab_j[i][j]  = 2'b00;
          tab_pc[i][j] = 2'b00;
        end
      tab_j[0][3]  = 2'b01;
      tab_pc[0][4] = 2'b10;
      tab_pc[0][0] = 2'b11;
      tab_pc[0][2] = 2'b01;
      tab_j[1][1]  = 2'b11;
      if (line <= 3) begin
        i_act = 3'd0; j_act = 3'd2; cur_pc = 1'b1;
      end else begin
        i_act = 3'd5; j_act = 3'd1; cur_pc = 1'b0;
      end
    end else begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          tab_j[i][j]  = 2'($urandom_range(0, 3));
          tab_pc[i][j] = 2'($urandom_range(0, 3));
        end
      i_act  = 3'($urandom_range(0, 7));
      j_act  = 3'($urandom_range(0, 7));
      cur_pc = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic compareDut(input int which, input int d, input int y0,
                            input logic vclk, input logic hs, input logic vs, input logic bn,
                            input logic sn, input logic fs, input logic [23:0] rgb);
    int c, p, hc, vc;
    logic evclk, efs, ehs, evs, ebn;
    logic [23:0] ergb;
    c = (cyc - 1) / d;
    p = c - 2;
    evclk = (cyc % d == 0);
    efs   = evclk && (c % 420000 == 0);
    ehs = 1'b1; evs = 1'b1; ebn = 1'b0; ergb = 24'h0; hc = -1; vc = -1;
    if (p >= 0) begin
      hc   = p % 800;
      vc   = (p / 800) % 525;
      ehs  = !(hc >= 656 && hc <= 751);
      evs  = !(vc >= 490 && vc <= 491);
      ebn  = (hc < 640 && vc < 480);
      ergb = refPixel(hc, vc, y0);
    end
    checkOutput(which == 1 ? "dut1 vga_clk" : "dut2 vga_clk", 24'(vclk), 24'(evclk));
    checkOutput(which == 1 ? "dut1 frame_start" : "dut2 frame_start", 24'(fs), 24'(efs));
    checkOutput(which == 1 ? "dut1 hsync" : "dut2 hsync", 24'(hs), 24'(ehs));
    checkOutput(which == 1 ? "dut1 vsync" : "dut2 vsync", 24'(vs), 24'(evs));
    checkOutput(which == 1 ? "dut1 blank_n" : "dut2 blank_n", 24'(bn), 24'(ebn));
    checkOutput(which == 1 ? "dut1 sync_n" : "dut2 sync_n", 24'(sn), 24'h0);
    checkOutput(which == 1 ? "dut1 rgb" : "dut2 rgb", rgb, ergb);
    for (int k = 0; k < 16; k++)
      if (vtab[k].dut == which && vtab[k].hc == hc && vtab[k].vc == vc)
        checkOutput($sformatf("table%0d dut%0d (%0d,%0d)", k, which, hc, vc), rgb, vtab[k].rgb);
  endtask

  task automatic checkReset();
    checkOutput("reset dut1 vga_clk", 24'(vclk1), 24'h0);
    checkOutput("reset dut1 hsync", 24'(hs1), 24'h1);
    checkOutput("reset dut1 vsync", 24'(vs1), 24'h1);
    checkOutput("reset dut1 blank_n", 24'(bn1), 24'h0);
    checkOutput("reset dut1 frame_start", 24'(fs1), 24'h0);
    checkOutput("reset dut1 rgb", {r1, g1, b1}, 24'h0);
    checkOutput("reset dut2 vga_clk", 24'(vclk2), 24'h0);
    checkOutput("reset dut2 hsync", 24'(hs2), 24'h1);
    checkOutput("reset dut2 vsync", 24'(vs2), 24'h1);
    checkOutput("reset dut2 blank_n", 24'(bn2), 24'h0);
    checkOutput("reset dut2 frame_start", 24'(fs2), 24'h0);
    checkOutput("reset dut2 rgb", {r2, g2, b2}, 24'h0);
  endtask

  task automatic runCycles(input int count);
    int p;
    for (int k = 0; k < count; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      compareDut(1, D1, Y1, vclk1, hs1, vs1, bn1, sn1, fs1, {r1, g1, b1});
      compareDut(2, D2, Y2, vclk2, hs2, vs2, bn2, sn2, fs2, {r2, g2, b2});
      p = (cyc - 1) / D1 - 2;
      if (p >= 0 && p % 800 == 700) applyStimulus(p / 800 + 1);
      if (miscompares > 40) begin
        $display("[TB] too many errors, stopping stimulus early");
        break;
      end
    end
  endtask

  initial begin
    vtab[0]  = '{1, 224,  2, 24'h00C000};
    vtab[1]  = '{1,  32,  2, 24'h0000C0};
    vtab[2]  = '{1, 320,  2, 24'hFFFFFF};
    vtab[3]  = '{1, 608,  3, 24'hC00000};
    vtab[4]  = '{1, 352,  3, 24'hA0A0A0};
`ifdef BOARD_CURSOR_EN
    vtab[5]  = '{1, 480,  3, 24'hFFFF00};
`else
    vtab[5]  = '{1, 480,  3, 24'h00C000};
`endif
    vtab[6]  = '{1, 160,  3, 24'h0000C0};
    vtab[7]  = '{1, 639,  1, 24'hFFFFFF};
    vtab[8]  = '{1, 100,  0, 24'hFFFFFF};
    vtab[9]  = '{1, 700,  1, 24'h000000};
    vtab[10] = '{1,  96, 66, 24'hA0A0A0};
    vtab[11] = '{1,  96, 64, 24'hFFFFFF};
    vtab[12] = '{1, 100, 65, 24'hA0A0A0};
    vtab[13] = '{2, 100, 20, 24'h202020};
    vtab[14] = '{2,   0,  5, 24'h202020};
    vtab[15] = '{2, 650,  5, 24'h000000};

    applyStimulus(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset();
    rst = 1'b0;
    cyc = 0;
    runCycles(800 * 68);

    // Mid-frame reset: outputs must drop asynchronously, then the raster restarts at (0,0).
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(0);
    cyc = 0;
    runCycles(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
